// File: rtl/fsc_pkg.sv
// Shared types and constants for the formula sweep checker.
// Holds the FSM state enum, default widths and the x/i variable mapping.
package fsc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int DEF_NUM_X = 4;
  localparam int DEF_NUM_I = 9;

  // Formula variable index carried by each vector bit, LSB first
  localparam int X_VAR [DEF_NUM_X] = '{0, 4, 5, 6};
  localparam int I_VAR [DEF_NUM_I] = '{1, 2, 3, 7, 8, 9, 10, 11, 12};

endpackage

// File: rtl/formula_sweep_checker_if.sv
// Bundle between the sweep checker and the external candidate/formula side.
// The slave side is the checker; the master side drives start, cand_i and fml_ok.
interface formula_sweep_checker_if
  import fsc_pkg::*;
#(
  parameter int NUM_X = DEF_NUM_X,
  parameter int NUM_I = DEF_NUM_I
) ();

  logic             start;
  logic [NUM_X-1:0] x_vec;
  logic [NUM_I-1:0] cand_i;
  logic             fml_ok;
  logic             busy;
  logic             done;
  logic             pass;
  logic [NUM_X:0]   fail_cnt;
  logic             cex_valid;
  logic [NUM_X-1:0] cex_x;
  logic [NUM_I-1:0] cex_i;

  modport master (
    output start, cand_i, fml_ok,
    input  x_vec, busy, done, pass, fail_cnt,
    input  cex_valid, cex_x, cex_i
  );

  modport slave (
    input  start, cand_i, fml_ok,
    output x_vec, busy, done, pass, fail_cnt,
    output cex_valid, cex_x, cex_i
  );

endinterface

// File: rtl/fsc_settle_timer.sv
// Loadable down-counter; expired is high once LAT cycles of settling have
// elapsed since the last load, giving LAT+1 settle cycles per vector.
module fsc_settle_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(LAT);
    end else if (en && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/formula_sweep_checker.sv
// Exhaustive sweep of all x assignments against an external formula,
// reporting pass, failure count and the lowest failing counterexample.
module formula_sweep_checker
  import fsc_pkg::*;
#(
  parameter int NUM_X    = DEF_NUM_X,
  parameter int NUM_I    = DEF_NUM_I,
  parameter int CAND_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  formula_sweep_checker_if.slave bus
);

  localparam logic [NUM_X-1:0] ONE_X = 1;
  localparam logic [NUM_X:0]   ONE_F = 1;

  state_t           state, state_n;
  logic [NUM_X-1:0] x_q, x_n;
  logic [NUM_X:0]   fail_q, fail_n;
  logic             pass_q, pass_n;
  logic             cexv_q, cexv_n;
  logic [NUM_X-1:0] cexx_q, cexx_n;
  logic [NUM_I-1:0] cexi_q, cexi_n;
  logic             busy_q, done_q;
  logic             load, expired;

  fsc_settle_timer #(
    .LAT (CAND_LAT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (state == S_SETTLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x_q;
    fail_n  = fail_q;
    pass_n  = pass_q;
    cexv_n  = cexv_q;
    cexx_n  = cexx_q;
    cexi_n  = cexi_q;
    load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          x_n     = '0;
          fail_n  = '0;
          pass_n  = 1'b0;
          cexv_n  = 1'b0;
          cexx_n  = '0;
          cexi_n  = '0;
          load    = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (expired) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (!bus.fml_ok) begin
          fail_n = fail_q + ONE_F;
          if (!cexv_q) begin
            cexv_n = 1'b1;
            cexx_n = x_q;
            cexi_n = bus.cand_i;
          end
        end
        // Verdict is latched here so it is valid while done is high
        if (&x_q) begin
          pass_n  = (fail_n == '0);
          state_n = S_DONE;
        end else begin
          x_n     = x_q + ONE_X;
          load    = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
      cexv_q <= 1'b0;
      cexx_q <= '0;
      cexi_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_n;
      fail_q <= fail_n;
      pass_q <= pass_n;
      cexv_q <= cexv_n;
      cexx_q <= cexx_n;
      cexi_q <= cexi_n;
      busy_q <= (state_n != S_IDLE);
      done_q <= (state_n == S_DONE);
    end
  end

  assign bus.x_vec     = x_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.cex_valid = cexv_q;
  assign bus.cex_x     = cexx_q;
  assign bus.cex_i     = cexi_q;

endmodule

// File: tb/tb_formula_sweep_checker.sv
// Scoreboard bench: two checkers (CAND_LAT 1 and 3) with bench-side
// candidate pipelines and formula models; done pulses are checked on pop.
module tb_formula_sweep_checker;
  import fsc_pkg::*;

  localparam int NX = 4;
  localparam int NI = 9;

  typedef struct {
    logic        pass;
    logic [4:0]  fc;
    logic        cv;
    logic [3:0]  cx;
    logic [8:0]  ci;
    int          edge_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   mode1 = 0;
  exp_t q1[$];
  exp_t q3[$];

  always @(posedge clk) cyc <= cyc + 1;

  formula_sweep_checker_if #(.NUM_X(NX), .NUM_I(NI)) b1 ();
  formula_sweep_checker_if #(.NUM_X(NX), .NUM_I(NI)) b3 ();

  formula_sweep_checker #(
    .NUM_X(NX), .NUM_I(NI), .CAND_LAT(1)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
  );

  formula_sweep_checker #(
    .NUM_X(NX), .NUM_I(NI), .CAND_LAT(3)
  ) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3.slave)
  );

  // Latency-1 candidate: 0x0A1 ^ x, so x=4'hA yields 9'h0AB
  logic [NI-1:0] c1;
  always @(posedge clk) c1 <= 9'h0A1 ^ {5'b0, b1.x_vec};
  assign b1.cand_i = c1;
  assign b1.fml_ok = (mode1 == 0) ? 1'b1 :
                     (mode1 == 1) ? !(b1.x_vec == 4'hA && c1 == 9'h0AB) :
                     1'b0;

  // Latency-3 candidate {x,1,x}; formula registered from the 2-stage copy
  function automatic logic [8:0] gfun(input logic [3:0] x);
    return {x, 1'b1, x};
  endfunction

  logic [NI-1:0] p1, p2, p3;
  logic          f3;
  always @(posedge clk) begin
    p1 <= gfun(b3.x_vec);
    p2 <= p1;
    p3 <= p2;
    f3 <= !(p2[3:0] == 4'd3 || p2[3:0] == 4'd7 || p2[3:0] == 4'd12);
  end
  assign b3.cand_i = p3;
  assign b3.fml_ok = f3;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic p,
                     input logic [4:0] fc, input logic cv,
                     input logic [3:0] cx, input logic [8:0] ci);
    chk({tag, "_edge"}, cyc, e.edge_n);
    chk({tag, "_pass"}, 32'(p), 32'(e.pass));
    chk({tag, "_fail_cnt"}, 32'(fc), 32'(e.fc));
    chk({tag, "_cex_valid"}, 32'(cv), 32'(e.cv));
    chk({tag, "_cex_x"}, 32'(cx), 32'(e.cx));
    chk({tag, "_cex_i"}, 32'(ci), 32'(e.ci));
  endtask

  always @(negedge clk) begin
    if (b1.done) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut1_unexpected_done: got done=1 expected 0 (cyc %0d)", cyc);
      end else begin
        cmp("dut1", q1.pop_front(), b1.pass, b1.fail_cnt, b1.cex_valid,
            b1.cex_x, b1.cex_i);
      end
    end
    if (b3.done) begin
      if (q3.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut3_unexpected_done: got done=1 expected 0 (cyc %0d)", cyc);
      end else begin
        cmp("dut3", q3.pop_front(), b3.pass, b3.fail_cnt, b3.cex_valid,
            b3.cex_x, b3.cex_i);
      end
    end
  end

  function automatic exp_t mk(input logic p, input logic [4:0] fc,
                              input logic cv, input logic [3:0] cx,
                              input logic [8:0] ci);
    exp_t e;
    e.pass = p; e.fc = fc; e.cv = cv; e.cx = cx; e.ci = ci; e.edge_n = 0;
    return e;
  endfunction

  // Start is sampled at edge cyc+1; done appears after 16*(LAT+2) more edges
  task automatic launch(input int which, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk);
    e.edge_n = cyc + 1 + 16 * ((which == 1) ? 3 : 5);
    if (which == 1) begin
      q1.push_back(e);
      b1.start = 1'b1;
    end else begin
      q3.push_back(e);
      b3.start = 1'b1;
    end
    @(negedge clk);
    b1.start = 1'b0;
    b3.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 1 && b1.done) || (which == 3 && b3.done)) break;
    end
    if (i == budget) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_dut%0d: got no done expected done within %0d", which, budget);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_x_vec"}, 32'(b1.x_vec), 0);
    chk({tag, "_busy"}, 32'(b1.busy), 0);
    chk({tag, "_done"}, 32'(b1.done), 0);
    chk({tag, "_pass"}, 32'(b1.pass), 0);
    chk({tag, "_fail_cnt"}, 32'(b1.fail_cnt), 0);
    chk({tag, "_cex_valid"}, 32'(b1.cex_valid), 0);
    chk({tag, "_cex_x"}, 32'(b1.cex_x), 0);
    chk({tag, "_cex_i"}, 32'(b1.cex_i), 0);
  endtask

  initial begin
    int i;
    rst1 = 1'b1;
    rst3 = 1'b1;
    b1.start = 1'b0;
    b3.start = 1'b0;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk_reset1("rst1");
    chk("rst3_busy", 32'(b3.busy), 0);
    chk("rst3_fail_cnt", 32'(b3.fail_cnt), 0);

    mode1 = 0;
    launch(1, mk(1'b1, 5'd0, 1'b0, 4'h0, 9'h000));
    chk("busy_after_start", 32'(b1.busy), 1);
    wait_done(1, 200);
    chk("busy_after_done", 32'(b1.busy), 0);
    chk("pass_held", 32'(b1.pass), 1);

    mode1 = 1;
    launch(1, mk(1'b0, 5'd1, 1'b1, 4'hA, 9'h0AB));
    wait_done(1, 200);

    mode1 = 2;
    launch(1, mk(1'b0, 5'd16, 1'b1, 4'h0, 9'h0A1));
    wait_done(1, 200);
    chk("fail_cnt_held", 32'(b1.fail_cnt), 16);

    launch(3, mk(1'b0, 5'd3, 1'b1, 4'h3, 9'h073));
    wait_done(3, 300);

    // Reset mid-sweep at x_vec=5: no done, no partial results
    mode1 = 2;
    @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    for (i = 0; i < 100 && b1.x_vec != 4'd5; i++) @(negedge clk);
    chk("reached_x5", 32'(b1.x_vec), 5);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk_reset1("midrst");
    repeat (60) @(negedge clk);
    chk("midrst_idle", 32'(b1.busy), 0);

    mode1 = 1;
    launch(1, mk(1'b0, 5'd1, 1'b1, 4'hA, 9'h0AB));
    repeat (10) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_done(1, 200);

    // Held start: back-to-back sweeps, done pulses 50 edges apart
    mode1 = 0;
    @(negedge clk);
    begin
      exp_t e;
      e = mk(1'b1, 5'd0, 1'b0, 4'h0, 9'h000);
      e.edge_n = cyc + 1 + 48;
      q1.push_back(e);
      e.edge_n = cyc + 1 + 48 + 50;
      q1.push_back(e);
    end
    b1.start = 1'b1;
    for (i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
    b1.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_stopped", 32'(b1.busy), 0);

    chk("q1_drained", 32'(q1.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/formula_sweep_checker.md
# formula_sweep_checker

Exhaustive sequential checker that sits around the combinational specification formula. It enumerates every assignment of the universally quantified `x` inputs and drives them out. It lets the upstream candidate-function block produce the `i` vector, then samples the formula's single-bit verdict. It reports pass/fail, a failure count and the first counterexample, which gives the result-checking flow a cycle-accurate hardware oracle for candidate Skolem functions.

## Interface
Parameters:
- `NUM_X`, default 4: number of `x` inputs swept. Bit mapping: `x_vec[0]`=x_0, `[1]`=x_4, `[2]`=x_5, `[3]`=x_6.
- `NUM_I`, default 9: width of the candidate `i` vector. Bit order LSB first: i_1, i_2, i_3, i_7, i_8, i_9, i_10, i_11, i_12.
- `CAND_LAT`, default 1: pipeline latency in cycles, from `x_vec` change to a valid `cand_i`/`fml_ok`. Legal range 0..15.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a sweep; single-cycle pulse or level.
- `x_vec` out NUM_X: current assignment driven to the candidate block and the formula.
- `cand_i` in NUM_I: candidate `i` values for the current `x_vec`.
- `fml_ok` in 1: formula output evaluated on (`x_vec`, `cand_i`).
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse at sweep completion.
- `pass` out 1: last sweep had zero failures.
- `fail_cnt` out NUM_X+1: number of failing assignments in the last sweep.
- `cex_valid` out 1: a counterexample was captured.
- `cex_x` out NUM_X: `x_vec` of the first (lowest-valued) failing assignment.
- `cex_i` out NUM_I: `cand_i` sampled with that failure.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - `start`=1 → clear `fail_cnt`, `pass`, `cex_*`; set `x_vec`=0, wait counter=0; go to SETTLE.
  - Otherwise hold results.
- SETTLE: increment the wait counter. When it reaches CAND_LAT, go to CHECK.
- CHECK: sample `fml_ok` and `cand_i`.
  - If `fml_ok`=0: `fail_cnt`+1. If `cex_valid`=0, capture `cex_x`=`x_vec`, `cex_i`=`cand_i`, and set `cex_valid`=1.
  - If `x_vec` is all ones, go to DONE.
  - Otherwise `x_vec`+1, clear the wait counter, go to SETTLE.
- DONE: `done`=1; `pass`=(`fail_cnt`==0), using the count including the final vector; go to IDLE.
- `busy`=1 in SETTLE, CHECK and DONE.
- `x_vec` is held constant for the whole SETTLE+CHECK window of each vector. It never wraps mid-sweep.
- `fail_cnt` maximum is 2^NUM_X, which fits NUM_X+1 bits, so no saturation is needed.
- `start` is ignored outside IDLE. A `start` held high across DONE launches a new sweep on the first IDLE cycle.
- Results (`pass`, `fail_cnt`, `cex_*`) remain stable from `done` until the next accepted `start`.

## Timing
- Reset values: state IDLE; `x_vec`=0, `busy`=0, `done`=0, `pass`=0, `fail_cnt`=0, `cex_valid`=0, `cex_x`=0, `cex_i`=0.
- `rst` mid-sweep forces all reset values on the next edge. No partial results survive, and no `done` is issued.
- Each vector occupies CAND_LAT+2 cycles: CAND_LAT+1 in SETTLE, 1 in CHECK.
- Cycle numbering: `start` sampled in IDLE at edge k. Then:
  - `busy`=1 and `x_vec`=0 from k+1.
  - `done` is high during cycle k+1+2^NUM_X·(CAND_LAT+2).
  - `busy` falls at the following edge.
- Timing for the defaults: CAND_LAT=1 gives 48 cycles from `start` to `done`.
- All outputs are registered. There is no combinational path from `fml_ok` or `cand_i` to any output.

## Structure
- Shared package `fsc_pkg` holds:
  - the state enum;
  - default `NUM_X`/`NUM_I`;
  - localparams for the x/i bit-index mapping, used by the bench and the wrapper that connects the formula.
- One natural sub-module: `fsc_settle_timer`, a loadable down-counter that generates the SETTLE-complete strobe from CAND_LAT.
- The formula and the candidate block are external. The bench or a top wrapper wires `x_vec`/`cand_i` to them and returns `fml_ok`.

## Test plan
- `fml_ok` tied 1, CAND_LAT=1, start at cycle 0 → `done` at cycle 49; `pass`=1, `fail_cnt`=0, `cex_valid`=0.
- `fml_ok`=0 only when `x_vec`=4'b1010 and `cand_i`=9'h0AB → `fail_cnt`=1, `cex_x`=4'b1010, `cex_i`=9'h0AB, `pass`=0.
- `fml_ok` tied 0 → `fail_cnt`=16, `cex_x`=0, `pass`=0.
- Model `cand_i` with CAND_LAT=3, delayed by the same pipeline, and drive `fml_ok` from the candidate vector delayed by 1 → first-failure capture is correct; `done` at start+1+80.
- Assert `rst` while `x_vec`=5 → next cycle all outputs at reset values, no `done`. A new `start` then completes a full 16-vector sweep.
- Pulse `start` while `busy`=1 → ignored, and the sweep length is unchanged. Hold `start` high continuously → back-to-back sweeps with one IDLE cycle between `done` pulses.
